// File: rtl/s832_bist_pkg.sv
// Shared types, widths and polynomial step helpers for the s832 BIST sequencer.
// The LFSR and MISR feedback taps are kept here so both sides agree on polynomials.
package s832_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } bist_state_e;

    localparam int unsigned PI_W    = 32'd18;
    localparam int unsigned PO_W    = 32'd19;
    localparam int unsigned LFSR_W  = 32'd17;
    localparam int unsigned CNT_W   = 32'd16;
    localparam int unsigned G18_BIT = 32'd17;

    // x^17+x^14+1 taps sit on bits 16 and 13; x^19+x^6+x^2+x+1 on bits 18, 5, 1, 0
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 17'h12000;
    localparam logic [PO_W-1:0]   MISR_TAPS = 19'h40023;

    function automatic logic [LFSR_W-1:0] lfsr_next_f(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [PO_W-1:0] misr_next_f(input logic [PO_W-1:0] cur,
                                                    input logic [PO_W-1:0] din);
        return {cur[PO_W-2:0], ^(cur & MISR_TAPS)} ^ din;
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1
    function automatic logic [LFSR_W-1:0] seed_fix_f(input logic [LFSR_W-1:0] seed);
        logic [LFSR_W-1:0] fixed;
        if (seed == {LFSR_W{1'b0}}) begin
            fixed = {{(LFSR_W-1){1'b0}}, 1'b1};
        end else begin
            fixed = seed;
        end
        return fixed;
    endfunction

endpackage

// File: rtl/s832_bist_if.sv
// Bundle of the BIST controller's test-side signals: the core I/O and the status outputs.
interface s832_bist_if;
    import s832_bist_pkg::*;

    logic              START;
    logic [PO_W-1:0]   CORE_PO;
    logic [PI_W-1:0]   CORE_PI;
    logic              BUSY;
    logic              DONE;
    logic              PASS;
    logic [PO_W-1:0]   SIG;

    modport master (
        input  START,
        input  CORE_PO,
        output CORE_PI,
        output BUSY,
        output DONE,
        output PASS,
        output SIG
    );

    modport slave (
        output START,
        output CORE_PO,
        input  CORE_PI,
        input  BUSY,
        input  DONE,
        input  PASS,
        input  SIG
    );
endinterface

// File: rtl/s832_bist_misr.sv
// 19-bit multiple-input signature register with synchronous clear and compaction enable.
module s832_bist_misr
    import s832_bist_pkg::*;
(
    input  logic            CK,
    input  logic            RST,
    input  logic            clr,
    input  logic            en,
    input  logic [PO_W-1:0] din,
    output logic [PO_W-1:0] sig
);

    logic [PO_W-1:0] misr_r;

    // Signature register: clear wins over compaction, otherwise hold
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            misr_r <= {PO_W{1'b0}};
        end else if (clr) begin
            misr_r <= {PO_W{1'b0}};
        end else if (en) begin
            misr_r <= misr_next_f(misr_r, din);
        end else begin
            misr_r <= misr_r;
        end
    end

    assign sig = misr_r;

endmodule

// File: rtl/s832_bist_ctrl.sv
// BIST sequencer for the s832 core: clears the core while idle, applies NPAT LFSR
// patterns, compacts the responses and compares the signature with GOLDEN.
module s832_bist_ctrl
    import s832_bist_pkg::*;
#(
    parameter int unsigned       NPAT   = 32'd256,
    parameter logic [16:0]       SEED   = 17'h00001,
    parameter logic [18:0]       GOLDEN = 19'h00000
) (
    input  logic        CK,
    input  logic        RST,
    s832_bist_if.master bus
);

    localparam logic [LFSR_W-1:0] SEED_EFF  = seed_fix_f(SEED);
    localparam logic [CNT_W-1:0]  NPAT_LAST = NPAT[CNT_W-1:0] - 16'd1;
    localparam logic              NPAT_ZERO = (NPAT == 32'd0);

    bist_state_e       state_r;
    bist_state_e       state_s;
    logic [LFSR_W-1:0] lfsr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              misr_clr_s;
    logic              misr_en_s;
    logic [PO_W-1:0]   sig_s;
    logic [PI_W-1:0]   pi_s;
    logic              busy_s;
    logic              done_s;

    // State register
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and MISR control strobes
    always_comb begin
        state_s    = state_r;
        misr_clr_s = 1'b0;
        misr_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.START) begin
                    state_s = ST_INIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                misr_clr_s = 1'b1;
                if (NPAT_ZERO) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                misr_en_s = 1'b1;
                if (cnt_r == NPAT_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.START) begin
                    state_s = ST_INIT;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Pattern generator and run-length counter; both freeze outside INIT/RUN
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            lfsr_r <= SEED_EFF;
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    lfsr_r <= SEED_EFF;
                    cnt_r  <= {CNT_W{1'b0}};
                end
                ST_RUN: begin
                    lfsr_r <= lfsr_next_f(lfsr_r);
                    cnt_r  <= cnt_r + 16'd1;
                end
                default: begin
                    lfsr_r <= lfsr_r;
                    cnt_r  <= cnt_r;
                end
            endcase
        end
    end

    s832_bist_misr u_misr (
        .CK  (CK),
        .RST (RST),
        .clr (misr_clr_s),
        .en  (misr_en_s),
        .din (bus.CORE_PO),
        .sig (sig_s)
    );

    // Output decode from registered state only; G18 held high except while patterns run
    always_comb begin
        pi_s          = {PI_W{1'b0}};
        pi_s[G18_BIT] = 1'b1;
        busy_s        = 1'b0;
        done_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_INIT: begin
                busy_s = 1'b1;
            end
            ST_RUN: begin
                busy_s = 1'b1;
                pi_s   = {1'b0, lfsr_r};
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign bus.CORE_PI = pi_s;
    assign bus.BUSY    = busy_s;
    assign bus.DONE    = done_s;
    assign bus.PASS    = done_s && (sig_s == GOLDEN);
    assign bus.SIG     = sig_s;

endmodule

// File: doc/s832_bist_ctrl.md
# s832_bist_ctrl

Built-in self-test sequencer for the s832 benchmark core. It holds the core in its synchronous clear (G18) while idle. On START it drives NPAT pseudo-random patterns from a 17-bit LFSR onto the core's primary inputs and compacts the 19 primary outputs into a 19-bit MISR each cycle. It then reports the signature and a pass/fail compare against a golden value. It sits beside the core instance in the test wrapper and owns every core input during test.

## Interface
- NPAT, 256: number of RUN cycles (patterns applied); legal range 0..65535.
- SEED, 17'h00001: initial LFSR state; a value of 0 is replaced by 17'h00001.
- GOLDEN, 19'h00000: expected final MISR signature.
- CK  input  1  clock, rising-edge.
- RST  input  1  asynchronous reset, active-high.
- START  input  1  begin a test; sampled only in IDLE or DONE.
- CORE_PO  input  19  core outputs. Bit order, bit 0 first: G288, G290, G292, G296, G298, G300, G302, G310, G312, G315, G322, G325, G327, G43, G45, G47, G49, G53, G55.
- CORE_PI  output  18  core inputs. Bits [16:0] drive G0..G16; bit [17] drives G18.
- BUSY  output  1  high in INIT and RUN.
- DONE  output  1  high in DONE.
- PASS  output  1  valid in DONE only: SIG == GOLDEN; 0 elsewhere.
- SIG  output  19  MISR contents; frozen in DONE.

## Operation
- States and transitions:
  - IDLE: on START go to INIT.
  - INIT: one cycle only; go to RUN if NPAT>0, otherwise to DONE.
  - RUN: stays for exactly NPAT cycles, then goes to DONE.
  - DONE: on START go to INIT.
- CORE_PI:
  - IDLE, INIT, DONE: 18'h20000 (G18=1, all other inputs 0), which holds the core state cleared.
  - RUN: {1'b0, lfsr}.
- INIT loads: lfsr ← SEED (0→1), misr ← 0, cnt ← 0.
- Each RUN edge, three updates happen together:
  - lfsr ← {lfsr[15:0], lfsr[16]^lfsr[13]} (x^17+x^14+1).
  - misr ← {misr[17:0], misr[18]^misr[5]^misr[1]^misr[0]} ^ CORE_PO (x^19+x^6+x^2+x+1).
  - cnt ← cnt+1. The RUN→DONE transition fires on the edge where cnt==NPAT-1.
- CORE_PO is sampled on the same edge that advances the pattern, so the response to pattern k is compacted at the end of RUN cycle k.
- START while BUSY is ignored. START held high in DONE restarts; PASS/SIG update at the next DONE.
- cnt is 16 bits and never wraps, because NPAT ≤ 65535.

## Timing
- Reset values: state IDLE, CORE_PI=18'h20000, BUSY=0, DONE=0, PASS=0, SIG=0, lfsr=SEED, cnt=0.
- Latency from START high at edge t:
  - INIT during cycle t+1.
  - First pattern on CORE_PI during cycle t+2.
  - DONE=1 during cycle t+2+NPAT; for NPAT=0 it is cycle t+2.
- All outputs are registered or decoded from state only. There is no combinational path from CORE_PO to any output.
- RST asserted mid-RUN: immediately returns all outputs to their reset values, asynchronously. G18 goes high in the same cycle.
- PASS and SIG remain stable for as long as the block stays in DONE.

## Structure
- Package s832_bist_pkg holds:
  - the state enum (IDLE, INIT, RUN, DONE);
  - constants PI_W=18, PO_W=19, LFSR_W=17, G18_BIT=17;
  - the LFSR tap mask 17'h12000 and the MISR tap mask 19'h40023.
- One sub-module, s832_bist_misr: 19-bit MISR with clear and enable, using CK and RST. The LFSR, counter and FSM stay in the top.
- Target size is roughly 150–220 lines of RTL in total.

## Test plan
- Reset with no START for 10 cycles → CORE_PI=18'h20000, BUSY=0, DONE=0, SIG=0.
- NPAT=2, SEED=1, CORE_PO tied to 19'h00001, START pulsed at edge 0:
  - CORE_PI=18'h00001 in cycle 2 and 18'h00002 in cycle 3;
  - DONE=1 in cycle 4 with SIG=19'h00002;
  - PASS=0 with GOLDEN=0, and PASS=1 with GOLDEN=19'h00002.
- NPAT=0 → DONE one cycle after INIT, SIG=0, PASS=1 with GOLDEN=0.
- SEED=0 → first RUN pattern is 18'h00001, i.e. identical to SEED=1.
- RST pulsed during RUN cycle 5 of NPAT=256 → all outputs return to reset values. A following START completes normally with the same SIG as an uninterrupted run.
- Connected to the real s832 core with NPAT=256 → SIG reproducible across two back-to-back STARTs from DONE. CORE_PI[17]=0 throughout RUN.
